// File: rtl/riscv_definitions.sv
// Shared RV32I encoding definitions: opcodes, immediate formats, FIFO entry.
package riscv_definitions;

  typedef enum logic [6:0] {
    LUI     = 7'b0110111,
    AUIPC   = 7'b0010111,
    JAL     = 7'b1101111,
    JALR    = 7'b1100111,
    BRCH_S  = 7'b1100011,
    LOAD_S  = 7'b0000011,
    STORE_S = 7'b0100011,
    ALUI_S  = 7'b0010011,
    ALU_S   = 7'b0110011
  } opcodeType;

  // Instruction format selector; IMM_IS is the shift-immediate flavour of I.
  typedef enum logic [2:0] {
    IMM_R  = 3'd0,
    IMM_I  = 3'd1,
    IMM_IS = 3'd2,
    IMM_S  = 3'd3,
    IMM_B  = 3'd4,
    IMM_U  = 3'd5,
    IMM_J  = 3'd6
  } imm_src_t;

  // ADDI x0,x0,0 -- substituted for any request that cannot be encoded.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } enc_entry_t;

  // True when v, read as two's complement, fits in a signed field of w bits,
  // i.e. bits 31 down to w-1 are all copies of the sign bit.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ((i >= int'(w) - 1) && (v[i] != v[31])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/riscv_instr_pack.sv
// Combinational RV32I field packer with immediate range checking.
module riscv_instr_pack
  import riscv_definitions::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  imm_src_t    fmt;
  logic        known;
  logic        range_ok;
  logic [31:0] raw;

  // Select the instruction format from the opcode; unknown opcodes flag an error.
  always_comb begin
    fmt   = IMM_R;
    known = 1'b1;
    case (opcode)
      LUI, AUIPC:     fmt = IMM_U;
      JAL:            fmt = IMM_J;
      JALR, LOAD_S:   fmt = IMM_I;
      ALUI_S:         fmt = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? IMM_IS : IMM_I;
      BRCH_S:         fmt = IMM_B;
      STORE_S:        fmt = IMM_S;
      ALU_S:          fmt = IMM_R;
      default: begin
        fmt   = IMM_R;
        known = 1'b0;
      end
    endcase
  end

  // Pack the fields for the selected format and check the immediate range.
  always_comb begin
    raw      = 32'h0;
    range_ok = 1'b1;
    case (fmt)
      IMM_I: begin
        raw      = {imm[11:0], rs1, funct3, rd, opcode};
        range_ok = fits_signed(imm, 12);
      end
      IMM_IS: begin
        raw      = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        range_ok = (imm[31:5] == 27'h0);
      end
      IMM_S: begin
        raw      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_ok = fits_signed(imm, 12);
      end
      IMM_B: begin
        raw      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_ok = fits_signed(imm, 13) && !imm[0];
      end
      IMM_U: begin
        raw      = {imm[31:12], rd, opcode};
        range_ok = (imm[11:0] == 12'h0);
      end
      IMM_J: begin
        raw      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_ok = fits_signed(imm, 21) && !imm[0];
      end
      default: begin
        raw      = {funct7, rs2, rs1, funct3, rd, opcode};
        range_ok = 1'b1;
      end
    endcase
  end

  assign err   = !known || !range_ok;
  assign instr = err ? NOP_INSTR : raw;

endmodule

// File: rtl/riscv_instr_encoder.sv
// RV32I instruction encoder: packs requests, assigns word addresses and
// buffers results in a 2-entry FIFO.
//
// Handshake: a transfer happens on a rising clk edge when valid && ready are
// both high; valid never waits on ready, and while valid is high without ready
// the payload holds stable. in_ready depends only on FIFO occupancy (no
// combinational path from out_ready), so a full FIFO stalls the input even in
// a cycle where the head is being popped.
module riscv_instr_encoder
  import riscv_definitions::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic        addr_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err
);

  logic [31:0] pack_instr;
  logic        pack_err;
  logic [31:0] addr_q;
  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic        push;
  logic        pop;
  enc_entry_t  mem [2];
  enc_entry_t  head;

  riscv_instr_pack u_pack (
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage: reset parks both slots at {0, BASE_ADDR, 0} so the idle outputs
  // read as a cleared entry; a push captures the pre-increment address.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '{instr: 32'h0, addr: BASE_ADDR, err: 1'b0};
      mem[1] <= '{instr: 32'h0, addr: BASE_ADDR, err: 1'b0};
    end else if (push) begin
      mem[wr_ptr] <= '{instr: pack_instr, addr: addr_q, err: pack_err};
    end
  end

  // Pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Word address counter; clear wins over increment, wraps naturally mod 2^32.
  always_ff @(posedge clk) begin
    if (rst || addr_clr) begin
      addr_q <= BASE_ADDR;
    end else if (push) begin
      addr_q <= addr_q + 32'd4;
    end
  end

  assign head      = mem[rd_ptr];
  assign out_instr = head.instr;
  assign out_addr  = head.addr;
  assign out_err   = head.err;

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Self-checking bench for riscv_instr_encoder: table-driven encodings plus
// hand-written backpressure, clear, wrap and reset sequences.
module tb_riscv_instr_encoder;

  localparam logic [31:0] WBASE = 32'hFFFF_FFF8;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        addr_clr = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr, out_addr;
  logic        w_in_ready, w_out_valid, w_out_err;
  logic [31:0] w_out_instr, w_out_addr;

  riscv_instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .addr_clr(addr_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
  );

  // Second instance starting near the top of the address space for wrap checks.
  riscv_instr_encoder #(.BASE_ADDR(WBASE)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .addr_clr(addr_clr), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_instr(w_out_instr), .out_addr(w_out_addr), .out_err(w_out_err)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [64:0] exp_q[$];   // {instr, addr, err}
  logic [31:0] wexp_q[$];  // wrap-instance addresses
  logic [31:0] m_addr = 32'h0;
  logic [31:0] w_addr = WBASE;
  logic [31:0] cur_instr = '0;
  logic        cur_err = 1'b0;
  vec_t        vt [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after posedge, so at negedge they describe the
  // transfers of the coming edge: pop/compare first, then model any accept.
  always @(negedge clk) begin
    logic [64:0] e;
    logic [31:0] wa;
    if (rst) begin
      exp_q.delete();
      wexp_q.delete();
      m_addr = 32'h0;
      w_addr = WBASE;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {31'h0, out_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("out_instr", out_instr, e[64:33]);
          chk("out_addr", out_addr, e[32:1]);
          chk("out_err", {31'h0, out_err}, {31'h0, e[0]});
        end
        chk("wrap_valid", {31'h0, w_out_valid}, 32'h1);
        if (wexp_q.size() != 0) begin
          wa = wexp_q.pop_front();
          chk("wrap_addr", w_out_addr, wa);
          chk("wrap_instr", w_out_instr, e[64:33]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({cur_instr, m_addr, cur_err});
        wexp_q.push_back(w_addr);
        m_addr = m_addr + 32'd4;
        w_addr = w_addr + 32'd4;
      end
      if (addr_clr) begin
        m_addr = 32'h0;
        w_addr = WBASE;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input vec_t v, input logic clr);
    int budget;
    in_valid  = 1'b1;
    in_opcode = v.op;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm    = v.imm;
    addr_clr  = clr;
    cur_instr = v.exp_instr;
    cur_err   = v.exp_err;
    budget    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 200) begin
        chk("accept_timeout", {31'h0, in_ready}, 32'h1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    addr_clr = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    vt[0]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5,          32'h0050_0093, 1'b0}; // ADDI x1,x0,5
    vt[1]  = '{7'h23, 5'd0, 5'd3, 5'd2, 3'b010, 7'h00, 32'd8,          32'h0021_A423, 1'b0}; // SW x2,8(x3)
    vt[2]  = '{7'h63, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_FFFC,  32'hFE00_0EE3, 1'b0}; // BEQ -4
    vt[3]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h1234_5000,  32'h1234_52B7, 1'b0}; // LUI
    vt[4]  = '{7'h13, 5'd1, 5'd1, 5'd0, 3'b101, 7'h20, 32'd3,          32'h4030_D093, 1'b0}; // SRAI
    vt[5]  = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd3,          32'h0000_0013, 1'b1}; // JAL odd
    vt[6]  = '{7'h13, 5'd1, 5'd1, 5'd0, 3'b101, 7'h20, 32'd32,         32'h0000_0013, 1'b1}; // SRAI 32
    vt[7]  = '{7'h7F, 5'd1, 5'd2, 5'd3, 3'b000, 7'h00, 32'd0,          32'h0000_0013, 1'b1}; // bad opcode
    vt[8]  = '{7'h13, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_F800,  32'h8000_0013, 1'b0}; // ADDI -2048
    vt[9]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd2048,       32'h0000_0013, 1'b1}; // ADDI 2048
    vt[10] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFF0_0000,  32'h8000_00EF, 1'b0}; // JAL min
    vt[11] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'd4096,       32'h0000_0013, 1'b1}; // B 4096
    vt[12] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'h1234_5001,  32'h0000_0013, 1'b1}; // LUI low bits
    vt[13] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'hDEAD_BEEF,  32'h0020_81B3, 1'b0}; // ADD
    vt[14] = '{7'h13, 5'd2, 5'd2, 5'd0, 3'b001, 7'h00, 32'd31,         32'h01F1_1113, 1'b0}; // SLLI 31
    vt[15] = '{7'h17, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_F000,  32'hFFFF_F097, 1'b0}; // AUIPC
    vt[16] = '{7'h03, 5'd4, 5'd5, 5'd0, 3'b010, 7'h00, 32'hFFFF_FFFF,  32'hFFF2_A203, 1'b0}; // LW -1
    vt[17] = '{7'h67, 5'd0, 5'd1, 5'd0, 3'b000, 7'h00, 32'd0,          32'h0000_8067, 1'b0}; // JALR
    vt[18] = '{7'h23, 5'd0, 5'd3, 5'd2, 3'b010, 7'h00, 32'hFFFF_F7FF,  32'h0000_0013, 1'b1}; // SW -2049
    vt[19] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'd5,          32'h0000_0013, 1'b1}; // B odd
    vt[20] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'h0010_0000,  32'h0000_0013, 1'b1}; // JAL 2^20
    vt[21] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'b001, 7'h00, 32'd4094,       32'h7E20_9FE3, 1'b0}; // BNE 4094

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_out_err", {31'h0, out_err}, 32'h0);
    chk("rst_wrap_addr", w_out_addr, WBASE);

    // ADDI with one-cycle latency
    out_ready = 1'b1;
    send(vt[0], 1'b0);
    chk("latency_valid", {31'h0, out_valid}, 32'h1);
    chk("latency_instr", out_instr, 32'h0050_0093);
    chk("latency_addr", out_addr, 32'h0);
    drain();

    // Table: back-to-back encodes from a fresh address, then the rest
    do_reset();
    for (int i = 1; i < 22; i++) send(vt[i], 1'b0);
    drain();

    // Backpressure: two accepts fill the FIFO, the third waits
    do_reset();
    out_ready = 1'b0;
    send(vt[1], 1'b0);
    send(vt[2], 1'b0);
    chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_instr", out_instr, 32'h0021_A423);
      chk("bp_hold_addr", out_addr, 32'h0);
      chk("bp_hold_valid", {31'h0, out_valid}, 32'h1);
    end
    fork
      send(vt[3], 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // addr_clr coincident with an accept, then wrap through the second instance
    do_reset();
    send(vt[13], 1'b0);
    send(vt[14], 1'b1);
    send(vt[15], 1'b0);
    drain();
    do_reset();
    for (int i = 0; i < 3; i++) send(vt[16 + i], 1'b0);
    drain();

    // Reset with two entries queued discards them
    do_reset();
    out_ready = 1'b0;
    send(vt[0], 1'b0);
    send(vt[4], 1'b0);
    chk("full_before_rst", {31'h0, in_ready}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_q_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_q_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_q_out_addr", out_addr, 32'h0);
    chk("rst_q_out_instr", out_instr, 32'h0);
    out_ready = 1'b1;
    send(vt[8], 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_instr_encoder.md
RISCV_INSTR_ENCODER -- requirements
Module: riscv_instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the word address assigned to the first encoded instruction after reset or clear.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  encode request valid.
REQ-005 in_ready  output  1  encoder can accept a request.
REQ-006 in_opcode  input  7  opcodeType value.
REQ-007 in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-008 in_funct3  input  3; in_funct7  input  7  function fields.
REQ-009 in_imm  input  32  immediate as full signed value; for U-type, the full upper value with its low 12 bits zero.
REQ-010 addr_clr  input  1  reset the address counter to BASE_ADDR.
REQ-011 out_valid  output  1; out_ready  input  1  output handshake.
REQ-012 out_instr  output  32  encoded instruction word.
REQ-013 out_addr  output  32  byte address of out_instr.
REQ-014 out_err  output  1  out_instr replaced by NOP because the request was illegal.

Function
REQ-015 Format select by opcode:
- LUI, AUIPC: U.
- JAL: J.
- JALR, LOAD_S: I.
- ALUI_S: I, except funct3 001 or 101, which are IS.
- BRCH_S: B.
- STORE_S: S.
- ALU_S: R.
REQ-016 Field placement SHALL follow the RV32I base encoding; R and IS formats take in_funct7 for bits 31:25; unused fields are ignored.
REQ-017 Immediate range rules:
- I and S: -2048..2047.
- IS: 0..31.
- B: -4096..4094, bit 0 zero.
- J: -1048576..1048574, bit 0 zero.
- U: in_imm[11:0] zero.
REQ-018 Unknown opcode or a range violation SHALL set out_err=1 and out_instr=NOP_INSTR (32'h0000_0013).
REQ-019 A request is accepted on a clock edge when in_valid && in_ready; the encoding and the current address are captured into a 2-entry FIFO.
REQ-020 in_ready = FIFO count < 2. There is no pass-through when full, even if out_ready=1.
REQ-021 Latency: a request accepted at edge N SHALL appear with out_valid=1 after edge N, when the FIFO was empty.
REQ-022 out_valid = count > 0. Outputs come from the FIFO head; an entry is popped when out_valid && out_ready.
REQ-023 Simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-024 Address counter SHALL increment by 4 on each acceptance and wrap modulo 2^32 (32'hFFFF_FFFC is followed by 0).
REQ-025 addr_clr SHALL set the counter to BASE_ADDR; if it coincides with an acceptance, the accepted entry keeps the pre-clear address and the next entry gets BASE_ADDR.
REQ-026 out_instr, out_addr and out_err SHALL hold stable while out_valid && !out_ready.

Reset
REQ-027 rst SHALL empty the FIFO and set the counter to BASE_ADDR, giving out_valid=0, in_ready=1, out_instr=0, out_addr=BASE_ADDR, out_err=0 after the edge.
REQ-028 rst SHALL override any concurrent push, pop or addr_clr; entries in flight are discarded.

Structure
REQ-029 NOP_INSTR and an enc_entry_t struct (instr, addr, err) SHALL be added to package riscv_definitions, reusing opcodeType and imm_src_t for format selection.
REQ-030 Field packing and range checking SHALL be a combinational sub-module riscv_instr_pack; FIFO, counter and handshake reside in riscv_instr_encoder.

Verification
REQ-031 ADDI x1,x0,5 after reset, out_ready=1 -> out_instr=32'h0050_0093, out_addr=0, out_err=0, one cycle after acceptance.
REQ-032 Back-to-back encodes -> exact words and consecutive addresses:
- SW x2,8(x3) -> 32'h0021_A423, addr 0.
- BEQ x0,x0,-4 -> 32'hFE00_0EE3, addr 4.
- LUI x5,0x12345000 -> 32'h1234_52B7, addr 8.
- SRAI x1,x1,3 (funct7 0100000) -> 32'h4030_D093, addr 12.
REQ-033 Illegal requests -> out_instr=32'h0000_0013, out_err=1, address still consumed:
- JAL imm=3.
- SRAI shamt=32.
- opcode 7'b1111111.
REQ-034 Backpressure: out_ready=0, three requests issued -> in_ready=0 after two accepts; release out_ready -> three words emitted in order at addrs 0,4,8.
REQ-035 Boundaries:
- addr_clr coincident with an accept -> that entry keeps its old address and the next entry gets 0.
- Counter at 32'hFFFF_FFFC -> next entry gets 0.
- rst with 2 entries queued -> out_valid=0 and in_ready=1 on the next cycle.
